// File: rtl/rx_data_controller.sv
// Receive data controller: strips 64b/66b framing from up to MAX_LINKS lanes and rebuilds
// AXI-Stream beats (data/keep/last) through a single-beat hold register.
module rx_data_controller #(
  parameter int unsigned MAX_LINKS              = 4,
  parameter int unsigned MAX_LINKS_SIZE         = 2,
  parameter int unsigned INTERMEDIATE_DATA_SIZE = 66,
  parameter int unsigned AXI_DATA_SIZE          = 64 * MAX_LINKS
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              single_lane_i,
  input  logic [MAX_LINKS_SIZE-1:0]                         lane_select_i,
  input  logic                                              channel_init_finished_i,
  input  logic [MAX_LINKS-1:0][INTERMEDIATE_DATA_SIZE-1:0] data_in_i,
  input  logic [MAX_LINKS-1:0]                              data_in_valid_i,
  output logic                                              axi_valid_o,
  output logic                                              axi_last_o,
  output logic [AXI_DATA_SIZE-1:0]                          axi_data_o,
  output logic [AXI_DATA_SIZE/8-1:0]                        axi_keep_o,
  output logic                                              frame_err_o
);
  localparam int unsigned KeepW = AXI_DATA_SIZE / 8;

  typedef enum logic [1:0] {KData, KIdle, KSep, KBad} kind_e;
  typedef enum logic {StIdle, StFrame} state_e;

  state_e state_q, state_d;

  kind_e       lane_kind [MAX_LINKS];
  logic [63:0] lane_data [MAX_LINKS];
  logic [7:0]  lane_keep [MAX_LINKS];

  logic [AXI_DATA_SIZE-1:0] new_data;
  logic [KeepW-1:0]         new_keep;
  logic has_sep, has_data, pat_err, proc, new_nonempty, sep_empty, emit;

  logic [AXI_DATA_SIZE-1:0] hold_data_q, hold_data_d, axi_data_d;
  logic [KeepW-1:0]         hold_keep_q, hold_keep_d, axi_keep_d;
  logic hold_valid_q, hold_valid_d, hold_last_q, hold_last_d;
  logic axi_valid_d, axi_last_d, frame_err_d;

  function automatic logic [63:0] expand_keep(input logic [7:0] keep);
    logic [63:0] mask;
    for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{keep[k]}};
    return mask;
  endfunction

  // Per-lane block decode; slot byte k lives in keep bit 7-k and data bits [63-8k -: 8].
  always_comb begin
    for (int j = 0; j < MAX_LINKS; j++) begin
      lane_kind[j] = KBad;
      lane_data[j] = '0;
      lane_keep[j] = '0;
      unique case (data_in_i[j][INTERMEDIATE_DATA_SIZE-1 -: 2])
        2'b01: begin
          lane_kind[j] = KData;
          lane_data[j] = data_in_i[j][63:0];
          lane_keep[j] = 8'hFF;
        end
        2'b10: begin
          unique case (data_in_i[j][63:56])
            8'h78: lane_kind[j] = KIdle;
            8'h1E: begin
              if (data_in_i[j][55:48] <= 8'd6) begin
                lane_kind[j] = KSep;
                for (int k = 0; k < 8; k++) begin
                  lane_keep[j][7-k] = (k < int'(data_in_i[j][55:48]));
                end
                lane_data[j] = {data_in_i[j][47:0], 16'h0} & expand_keep(lane_keep[j]);
              end
            end
            8'hE1: begin
              lane_kind[j] = KSep;
              lane_data[j] = {data_in_i[j][55:0], 8'h0};
              lane_keep[j] = 8'hFE;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Pattern check D* [SEP] I* over active lanes; lane 0 fills the most significant slot.
  always_comb begin : scan
    logic tail;
    int   slot;
    tail     = 1'b0;
    slot     = 0;
    new_data = '0;
    new_keep = '0;
    has_sep  = 1'b0;
    has_data = 1'b0;
    pat_err  = 1'b0;
    for (int j = 0; j < MAX_LINKS; j++) begin
      if (!single_lane_i || lane_select_i == MAX_LINKS_SIZE'(j)) begin
        slot = single_lane_i ? 0 : int'(MAX_LINKS) - 1 - j;
        unique case (lane_kind[j])
          KData: begin
            if (tail) pat_err = 1'b1;
            has_data = 1'b1;
          end
          KSep: begin
            if (tail || (!has_data && state_q == StIdle)) pat_err = 1'b1;
            has_sep = 1'b1;
            tail    = 1'b1;
          end
          KIdle:   tail = 1'b1;
          default: pat_err = 1'b1;
        endcase
        new_data[64*slot +: 64] = lane_data[j];
        new_keep[8*slot +: 8]   = lane_keep[j];
      end
    end
  end

  assign proc         = single_lane_i ? data_in_valid_i[lane_select_i] : &data_in_valid_i;
  assign new_nonempty = |new_keep;
  assign sep_empty    = has_sep && !new_nonempty;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!channel_init_finished_i) begin
      state_d = StIdle;
    end else if (proc) begin
      if (pat_err || has_sep) state_d = StIdle;
      else if (has_data)      state_d = StFrame;
    end
  end

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    emit         = 1'b0;
    frame_err_d  = 1'b0;
    if (channel_init_finished_i) begin
      // A final beat leaves the hold register on the very next edge, error or not.
      if (hold_valid_q && hold_last_q) emit = 1'b1;
      if (proc && !pat_err && hold_valid_q &&
          (new_nonempty || (sep_empty && state_q == StFrame))) emit = 1'b1;
      frame_err_d = proc && pat_err;
    end
    axi_valid_d = emit;
    axi_last_d  = emit && (hold_last_q || (proc && sep_empty));
    axi_data_d  = emit ? hold_data_q : '0;
    axi_keep_d  = emit ? hold_keep_q : '0;

    if (!channel_init_finished_i || (proc && pat_err) || (emit && !(proc && new_nonempty))) begin
      hold_data_d  = '0;
      hold_keep_d  = '0;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
    end else if (proc && new_nonempty) begin
      hold_data_d  = new_data;
      hold_keep_d  = new_keep;
      hold_valid_d = 1'b1;
      hold_last_d  = has_sep;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      axi_valid_o  <= 1'b0;
      axi_last_o   <= 1'b0;
      axi_data_o   <= '0;
      axi_keep_o   <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      axi_valid_o  <= axi_valid_d;
      axi_last_o   <= axi_last_d;
      axi_data_o   <= axi_data_d;
      axi_keep_o   <= axi_keep_d;
      frame_err_o  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_rx_data_controller.sv
// Directed, table-driven bench for rx_data_controller with hand-computed beats.
module tb_rx_data_controller;
  typedef logic [65:0] blk_t;

  typedef struct {
    string        name;
    logic         rst;
    logic         sl;
    logic [1:0]   sel;
    logic         cif;
    logic [3:0]   vld;
    blk_t         b0, b1, b2, b3;
    logic         ev, el, ee;
    logic [31:0]  ek;
    logic [255:0] ed;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            single_lane = 1'b0;
  logic [1:0]      lane_select = 2'd0;
  logic            channel_init_finished = 1'b0;
  logic [3:0][65:0] data_in = '0;
  logic [3:0]      data_in_valid = '0;
  logic            axi_valid, axi_last, frame_err;
  logic [255:0]    axi_data;
  logic [31:0]     axi_keep;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  localparam blk_t IDL = {2'b10, 8'h78, 56'h0};
  localparam blk_t BAD = {2'b11, 64'h0};

  rx_data_controller dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .single_lane_i           (single_lane),
    .lane_select_i           (lane_select),
    .channel_init_finished_i (channel_init_finished),
    .data_in_i               (data_in),
    .data_in_valid_i         (data_in_valid),
    .axi_valid_o             (axi_valid),
    .axi_last_o              (axi_last),
    .axi_data_o              (axi_data),
    .axi_keep_o              (axi_keep),
    .frame_err_o             (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] p(input logic [7:0] b);
    return {8{b}};
  endfunction
  function automatic blk_t d(input logic [7:0] b);
    return {2'b01, {8{b}}};
  endfunction
  function automatic blk_t dw(input logic [63:0] x);
    return {2'b01, x};
  endfunction
  function automatic blk_t sep(input logic [7:0] n, input logic [47:0] x);
    return {2'b10, 8'h1E, n, x};
  endfunction
  function automatic blk_t sep7(input logic [55:0] x);
    return {2'b10, 8'hE1, x};
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic sl,
                              input logic [1:0] sel, input logic cif, input logic [3:0] vld,
                              input blk_t b0, input blk_t b1, input blk_t b2, input blk_t b3,
                              input logic ev, input logic el, input logic ee,
                              input logic [31:0] ek, input logic [255:0] ed);
    vec_t v;
    v.name = nm; v.rst = r; v.sl = sl; v.sel = sel; v.cif = cif; v.vld = vld;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.ev = ev; v.el = el; v.ee = ee; v.ek = ek; v.ed = ed;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [290:0] act, exp;
    @(negedge clk);
    rst                   = v.rst;
    single_lane           = v.sl;
    lane_select           = v.sel;
    channel_init_finished = v.cif;
    data_in_valid         = v.vld;
    data_in               = {v.b3, v.b2, v.b1, v.b0};
    @(posedge clk);
    #1;
    act = {axi_valid, axi_last, frame_err, axi_keep, axi_data};
    exp = {v.ev, v.el, v.ee, v.ek, v.ed};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b l=%b e=%b keep=%h data=%h / want v=%b l=%b e=%b keep=%h data=%h",
               v.name, axi_valid, axi_last, frame_err, axi_keep, axi_data,
               v.ev, v.el, v.ee, v.ek, v.ed);
    end
  endtask

  initial begin
    // Single lane on lane 2; other lanes carry garbage that must be ignored.
    vecs.push_back(mk("reset", 1, 0, 0, 0, 4'h0, IDL, IDL, IDL, IDL, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sl_d1", 0, 1, 2, 1, 4'b0100, BAD, BAD, dw(64'h1122334455667788), BAD,
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("sl_d2", 0, 1, 2, 1, 4'b0100, BAD, BAD, dw(64'hAABBCCDDEEFF0011), BAD,
                      1, 0, 0, 32'hFF, {192'h0, 64'h1122334455667788}));
    vecs.push_back(mk("sl_sep3", 0, 1, 2, 1, 4'b0100, BAD, BAD, sep(3, 48'hC1C2C3DDEEFF), BAD,
                      1, 0, 0, 32'hFF, {192'h0, 64'hAABBCCDDEEFF0011}));
    vecs.push_back(mk("sl_last", 0, 1, 2, 1, 4'b0100, BAD, BAD, IDL, BAD,
                      1, 1, 0, 32'hE0, {192'h0, 64'hC1C2C30000000000}));
    vecs.push_back(mk("mode_chg", 0, 0, 0, 0, 4'h0, IDL, IDL, IDL, IDL, 0, 0, 0, 0, 0));
    // Four lanes: frame end on SEP n=0 in lane 0.
    vecs.push_back(mk("4l_dddd", 0, 0, 0, 1, 4'hF, d(8'hA0), d(8'hA1), d(8'hA2), d(8'hA3),
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("4l_sep0", 0, 0, 0, 1, 4'hF, sep(0, 48'h123456789ABC), IDL, IDL, IDL,
                      1, 1, 0, 32'hFFFFFFFF, {p(8'hA0), p(8'hA1), p(8'hA2), p(8'hA3)}));
    vecs.push_back(mk("4l_quiet", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 0, 0, 0, 0, 0));
    // Open and close in one cycle; the final beat leaves on a non-processing cycle.
    vecs.push_back(mk("oc_dds7i", 0, 0, 0, 1, 4'hF, d(8'hB0), d(8'hB1),
                      sep7(56'hC0C1C2C3C4C5C6), IDL, 0, 0, 0, 0, 0));
    vecs.push_back(mk("oc_out_novld", 0, 0, 0, 1, 4'h0, BAD, BAD, BAD, BAD, 1, 1, 0,
                      32'hFFFFFE00, {p(8'hB0), p(8'hB1), 64'hC0C1C2C3C4C5C600, 64'h0}));
    // Pattern errors, each followed by a clean frame.
    vecs.push_back(mk("err_didi", 0, 0, 0, 1, 4'hF, d(8'hE1), IDL, d(8'hE2), IDL,
                      0, 0, 1, 0, 0));
    vecs.push_back(mk("clean1", 0, 0, 0, 1, 4'hF, d(8'hE0), sep(2, 48'hF1F2AAAAAAAA), IDL, IDL,
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("clean1_out", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 1, 1, 0,
                      32'hFFC00000, {p(8'hE0), 64'hF1F2000000000000, 128'h0}));
    vecs.push_back(mk("err_sep_idle", 0, 0, 0, 1, 4'hF, sep(1, 48'h999999999999), IDL, IDL, IDL,
                      0, 0, 1, 0, 0));
    vecs.push_back(mk("clean2_dddd", 0, 0, 0, 1, 4'hF, d(8'h60), d(8'h61), d(8'h62), d(8'h63),
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("clean2_dsep", 0, 0, 0, 1, 4'hF, d(8'h70), sep(0, 48'h0), IDL, IDL,
                      1, 0, 0, 32'hFFFFFFFF, {p(8'h60), p(8'h61), p(8'h62), p(8'h63)}));
    vecs.push_back(mk("err_hdr11_last", 0, 0, 0, 1, 4'hF, d(8'h71), BAD, IDL, IDL,
                      1, 1, 1, 32'hFF000000, {p(8'h70), 192'h0}));
    vecs.push_back(mk("clean3_dddd", 0, 0, 0, 1, 4'hF, d(8'h80), d(8'h81), d(8'h82), d(8'h83),
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("clean3_sep7", 0, 0, 0, 1, 4'hF, sep7(56'h11223344556677), IDL, IDL, IDL,
                      1, 0, 0, 32'hFFFFFFFF, {p(8'h80), p(8'h81), p(8'h82), p(8'h83)}));
    vecs.push_back(mk("clean3_out", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 1, 1, 0,
                      32'hFE000000, {64'h1122334455667700, 192'h0}));
    // Mid-frame error must drop the held beat without emitting it.
    vecs.push_back(mk("mid_dddd", 0, 0, 0, 1, 4'hF, d(8'h90), d(8'h91), d(8'h92), d(8'h93),
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("mid_didi", 0, 0, 0, 1, 4'hF, d(8'h94), IDL, d(8'h95), IDL,
                      0, 0, 1, 0, 0));
    vecs.push_back(mk("after_drop", 0, 0, 0, 1, 4'hF, d(8'h96), sep(0, 48'h0), IDL, IDL,
                      0, 0, 0, 0, 0));
    vecs.push_back(mk("after_drop_out", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 1, 1, 0,
                      32'hFF000000, {p(8'h96), 192'h0}));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Lane 2 valid low for three cycles mid-frame.
    step(mk("gap_dddd", 0, 0, 0, 1, 4'hF, d(8'hA4), d(8'hA5), d(8'hA6), d(8'hA7),
            0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step(mk("gap_hold", 0, 0, 0, 1, 4'b1011, BAD, BAD, BAD, BAD, 0, 0, 0, 0, 0));
    end
    step(mk("gap_resume", 0, 0, 0, 1, 4'hF, d(8'hB4), d(8'hB5), d(8'hB6), d(8'hB7),
            1, 0, 0, 32'hFFFFFFFF, {p(8'hA4), p(8'hA5), p(8'hA6), p(8'hA7)}));
    step(mk("gap_sep0", 0, 0, 0, 1, 4'hF, sep(0, 48'h0), IDL, IDL, IDL,
            1, 1, 0, 32'hFFFFFFFF, {p(8'hB4), p(8'hB5), p(8'hB6), p(8'hB7)}));
    step(mk("gap_quiet", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 0, 0, 0, 0, 0));

    // Channel drop mid-frame discards the pending beat.
    step(mk("cif_dddd", 0, 0, 0, 1, 4'hF, d(8'hC4), d(8'hC5), d(8'hC6), d(8'hC7),
            0, 0, 0, 0, 0));
    step(mk("cif_drop", 0, 0, 0, 0, 4'hF, d(8'hC8), BAD, d(8'hC9), IDL, 0, 0, 0, 0, 0));
    step(mk("cif_next", 0, 0, 0, 1, 4'hF, d(8'hD0), sep(4, 48'h515253545556), IDL, IDL,
            0, 0, 0, 0, 0));
    step(mk("cif_next_out", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 1, 1, 0,
            32'hFFF00000, {p(8'hD0), 64'h5152535400000000, 128'h0}));

    // Reset mid-frame: FSM back to idle, so a bare separator is then an error.
    step(mk("rst_dddd", 0, 0, 0, 1, 4'hF, d(8'hE4), d(8'hE5), d(8'hE6), d(8'hE7),
            0, 0, 0, 0, 0));
    step(mk("rst_pulse", 1, 0, 0, 1, 4'hF, d(8'hE8), d(8'hE9), d(8'hEA), d(8'hEB),
            0, 0, 0, 0, 0));
    step(mk("rst_sep_idle", 0, 0, 0, 1, 4'hF, sep7(56'h0), IDL, IDL, IDL, 0, 0, 1, 0, 0));
    step(mk("rst_next", 0, 0, 0, 1, 4'hF, d(8'hF0), sep7(56'h61626364656667), IDL, IDL,
            0, 0, 0, 0, 0));
    step(mk("rst_next_out", 0, 0, 0, 1, 4'hF, IDL, IDL, IDL, IDL, 1, 1, 0,
            32'hFFFE0000, {p(8'hF0), 64'h6162636465666700, 128'h0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
